// File: rtl/multiplier_pkg.sv
// Shared register offsets, STATUS bit positions and FSM encoding for the
// memory-mapped 64x64 shift-add multiplier.
package multiplier_pkg;

  localparam logic [3:0] ADDR_MCAND_L  = 4'h0;
  localparam logic [3:0] ADDR_MCAND_H  = 4'h1;
  localparam logic [3:0] ADDR_MPLIER_L = 4'h2;
  localparam logic [3:0] ADDR_MPLIER_H = 4'h3;
  localparam logic [3:0] ADDR_INTR_EN  = 4'h4;
  localparam logic [3:0] ADDR_OPSTART  = 4'h5;
  localparam logic [3:0] ADDR_OPCLEAR  = 4'h6;
  localparam logic [3:0] ADDR_STATUS   = 4'h7;
  localparam logic [3:0] ADDR_RESULT_L = 4'h8;
  localparam logic [3:0] ADDR_RESULT_H = 4'h9;

  localparam int STATUS_DONE = 0;
  localparam int STATUS_BUSY = 1;
  localparam int STATUS_OVF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/multiplier_slave_if.sv
// Register-bus connection between a bus master and the multiplier slave:
// single-cycle select/write strobes, combinational read data, interrupt back.
interface multiplier_slave_if;
  logic        s_sel;
  logic        s_wr;
  logic [3:0]  s_addr;
  logic [31:0] s_din;
  logic [31:0] s_dout;
  logic        m_interrupt;

  modport slave  (input  s_sel, s_wr, s_addr, s_din, output s_dout, m_interrupt);
  modport master (output s_sel, s_wr, s_addr, s_din, input  s_dout, m_interrupt);
endinterface

// File: rtl/multiplier_core.sv
// Radix-2 shift-add datapath: start latches operands, then exactly 64 steps.
// done is high during the 64th step; prod shows the accumulator value that edge loads.
module multiplier_core (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         clear,
  input  logic [63:0]  mcand,
  input  logic [63:0]  mplier,
  output logic         done,
  output logic [127:0] prod
);

  logic         run_q,    run_d;
  logic [5:0]   cnt_q,    cnt_d;
  logic [127:0] acc_q,    acc_d;
  logic [127:0] mcand_q,  mcand_d;
  logic [63:0]  mplier_q, mplier_d;

  always_comb begin
    run_d    = run_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    done     = run_q && (cnt_q == 6'd63) && !clear;
    if (clear) begin
      run_d    = 1'b0;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = '0;
      mplier_d = '0;
    end else if (start) begin
      run_d    = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = {64'd0, mcand};
      mplier_d = mplier;
    end else if (run_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 6'd1;
      // counter wraps to 0 on the last step, leaving it ready for the next run
      if (cnt_q == 6'd63) run_d = 1'b0;
    end
    prod = acc_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/multiplier_slave.sv
// Bus slave wrapping the shift-add core: register decode, IDLE/EXEC/DONE FSM, interrupt.
// Writes land on the next edge; reads are combinational; DONE appears 64 edges after OPSTART.
module multiplier_slave
  import multiplier_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  multiplier_slave_if.slave  bus
);

  state_e       state_q,  state_d;
  logic [63:0]  mcand_q,  mcand_d;
  logic [63:0]  mplier_q, mplier_d;
  logic         ie_q,     ie_d;
  logic [63:0]  result_q, result_d;
  logic         ovf_q,    ovf_d;

  logic         wr_en, start, clear, core_done, busy, done;
  logic [127:0] core_prod;
  logic [31:0]  status;

  assign wr_en = bus.s_sel && bus.s_wr;
  assign start = wr_en && (bus.s_addr == ADDR_OPSTART) && bus.s_din[0] && (state_q == ST_IDLE);
  assign clear = wr_en && (bus.s_addr == ADDR_OPCLEAR) && bus.s_din[0];
  assign busy  = (state_q == ST_EXEC);
  assign done  = (state_q == ST_DONE);

  multiplier_core u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .clear   (clear),
    .mcand   (mcand_q),
    .mplier  (mplier_q),
    .done    (core_done),
    .prod    (core_prod)
  );

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    ie_d     = ie_q;
    if (wr_en) begin
      case (bus.s_addr)
        ADDR_MCAND_L:  if (!busy) mcand_d[31:0]   = bus.s_din;
        ADDR_MCAND_H:  if (!busy) mcand_d[63:32]  = bus.s_din;
        ADDR_MPLIER_L: if (!busy) mplier_d[31:0]  = bus.s_din;
        ADDR_MPLIER_H: if (!busy) mplier_d[63:32] = bus.s_din;
        ADDR_INTR_EN:  ie_d = bus.s_din[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d  = ST_EXEC;
        result_d = '0;
        ovf_d    = 1'b0;
      end
      ST_EXEC: if (core_done) begin
        state_d  = ST_DONE;
        result_d = core_prod[63:0];
        ovf_d    = |core_prod[127:64];
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase
    // clear wins from any state, including an abort mid-EXEC
    if (clear) begin
      state_d  = ST_IDLE;
      result_d = '0;
      ovf_d    = 1'b0;
    end
  end

  always_comb begin
    status                = '0;
    status[STATUS_DONE]   = done;
    status[STATUS_BUSY]   = busy;
    status[STATUS_OVF]    = ovf_q;
    bus.s_dout            = '0;
    if (bus.s_sel && !bus.s_wr) begin
      case (bus.s_addr)
        ADDR_MCAND_L:  bus.s_dout = mcand_q[31:0];
        ADDR_MCAND_H:  bus.s_dout = mcand_q[63:32];
        ADDR_MPLIER_L: bus.s_dout = mplier_q[31:0];
        ADDR_MPLIER_H: bus.s_dout = mplier_q[63:32];
        ADDR_INTR_EN:  bus.s_dout = {31'd0, ie_q};
        ADDR_STATUS:   bus.s_dout = status;
        ADDR_RESULT_L: bus.s_dout = result_q[31:0];
        ADDR_RESULT_H: bus.s_dout = result_q[63:32];
        default:       bus.s_dout = '0;
      endcase
    end
    bus.m_interrupt = done && ie_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      ie_q     <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      ie_q     <= ie_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_multiplier_slave.sv
// Scoreboard bench for multiplier_slave: every driven cycle queues the expected read
// data and interrupt from a transaction-level model; a negedge monitor pops and compares.
module tb_multiplier_slave;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  multiplier_slave_if bus ();

  multiplier_slave dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_dout_q [$];
  logic        exp_irq_q  [$];
  string       exp_tag_q  [$];

  // reference model: operation state as plain flags plus a countdown
  logic [63:0]  m_mcand, m_mplier, m_res;
  logic [127:0] m_prod;
  logic         m_ie, m_ovf, m_busy, m_done;
  int           m_left;

  task automatic model_reset();
    m_mcand = '0; m_mplier = '0; m_res = '0; m_prod = '0;
    m_ie = 1'b0; m_ovf = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a)
      4'h0: return m_mcand[31:0];
      4'h1: return m_mcand[63:32];
      4'h2: return m_mplier[31:0];
      4'h3: return m_mplier[63:32];
      4'h4: return {31'd0, m_ie};
      4'h7: return {29'd0, m_ovf, m_busy, m_done};
      4'h8: return m_res[31:0];
      4'h9: return m_res[63:32];
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge(input logic sel, input logic wr, input logic [3:0] a, input logic [31:0] d);
    logic was_busy, was_done;
    was_busy = m_busy;
    was_done = m_done;
    if (was_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_res  = m_prod[63:0];
        m_ovf  = (m_prod[127:64] != 0);
      end
    end
    if (sel && wr) begin
      if (a == 4'h0 && !was_busy) m_mcand[31:0]   = d;
      if (a == 4'h1 && !was_busy) m_mcand[63:32]  = d;
      if (a == 4'h2 && !was_busy) m_mplier[31:0]  = d;
      if (a == 4'h3 && !was_busy) m_mplier[63:32] = d;
      if (a == 4'h4) m_ie = d[0];
      if (a == 4'h5 && d[0] && !was_busy && !was_done) begin
        m_busy = 1'b1;
        m_left = 64;
        m_prod = 128'(m_mcand) * 128'(m_mplier);
        m_res  = '0;
        m_ovf  = 1'b0;
      end
      if (a == 4'h6 && d[0]) begin
        m_busy = 1'b0; m_done = 1'b0; m_res = '0; m_ovf = 1'b0;
      end
    end
  endtask

  // one bus cycle; use_k selects a fixed expected read value instead of the model's
  task automatic cycle(input logic sel, input logic wr, input logic [3:0] a, input logic [31:0] d,
                       input logic use_k, input logic [31:0] k, input string tag);
    bus.s_sel  = sel;
    bus.s_wr   = wr;
    bus.s_addr = a;
    bus.s_din  = d;
    exp_dout_q.push_back((sel && !wr) ? (use_k ? k : model_read(a)) : 32'd0);
    exp_irq_q.push_back(m_done && m_ie);
    exp_tag_q.push_back(tag);
    @(posedge clk);
    model_edge(sel, wr, a, d);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b1, a, d, 1'b0, 32'd0, "write");
  endtask
  task automatic rd(input logic [3:0] a, input string tag);
    cycle(1'b1, 1'b0, a, 32'd0, 1'b0, 32'd0, tag);
  endtask
  task automatic rdk(input logic [3:0] a, input logic [31:0] k, input string tag);
    cycle(1'b1, 1'b0, a, 32'd0, 1'b1, k, tag);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'h0, 32'd0, 1'b0, 32'd0, "idle");
  endtask

  task automatic load(input logic [63:0] a, input logic [63:0] b, input logic ie);
    wr(4'h0, a[31:0]); wr(4'h1, a[63:32]);
    wr(4'h2, b[31:0]); wr(4'h3, b[63:32]);
    wr(4'h4, {31'd0, ie});
  endtask

  always @(negedge clk) begin
    if (exp_dout_q.size() > 0) begin
      logic [31:0] ed;
      logic        ei;
      string       et;
      ed = exp_dout_q.pop_front();
      ei = exp_irq_q.pop_front();
      et = exp_tag_q.pop_front();
      total++;
      if (bus.s_dout !== ed) begin
        bad++;
        $display("FAIL %s s_dout: got %h want %h (addr %h)", et, bus.s_dout, ed, bus.s_addr);
      end
      total++;
      if (bus.m_interrupt !== ei) begin
        bad++;
        $display("FAIL %s m_interrupt: got %b want %b", et, bus.m_interrupt, ei);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] a, b;
    logic [3:0]  ra;
    bus.s_sel = 1'b0; bus.s_wr = 1'b0; bus.s_addr = '0; bus.s_din = '0;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 16; i++) rdk(4'(i), 32'd0, "reset value");

    // 5 x 6 with interrupt enabled: 64 busy samples then done
    load(64'd5, 64'd6, 1'b1);
    wr(4'h5, 32'd1);
    for (int i = 0; i < 64; i++) rdk(4'h7, 32'd2, "busy window");
    rdk(4'h7, 32'd1, "done after 64");
    rdk(4'h8, 32'd30, "5x6 result_l");
    rdk(4'h9, 32'd0, "5x6 result_h");
    rdk(4'h5, 32'd0, "opstart reads 0");
    rdk(4'h6, 32'd0, "opclear reads 0");
    wr(4'h5, 32'd1);
    rdk(4'h7, 32'd1, "opstart ignored in done");
    wr(4'h6, 32'd1);
    rdk(4'h7, 32'd0, "cleared status");
    rdk(4'h8, 32'd0, "cleared result");
    rdk(4'h0, 32'd5, "mcand kept");
    rdk(4'h4, 32'd1, "ie kept");

    // 20! x 21 overflows 64 bits
    load(64'h21C3677C82B40000, 64'd21, 1'b1);
    wr(4'h5, 32'd1);
    idle(64);
    rdk(4'h7, 32'd5, "20!x21 status");
    rdk(4'h8, 32'hB8C40000, "20!x21 result_l");
    rdk(4'h9, 32'hC5077D36, "20!x21 result_h");
    wr(4'h6, 32'd1);

    // interrupt masked, then enabled after completion
    load(64'd3, 64'd4, 1'b0);
    wr(4'h5, 32'd1);
    idle(64);
    rdk(4'h7, 32'd1, "3x4 done masked");
    wr(4'h4, 32'd1);
    idle(1);
    rdk(4'h8, 32'd12, "3x4 result");
    wr(4'h6, 32'd1);

    // abort at EXEC cycle 20, then rerun
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    load(a, b, 1'b1);
    wr(4'h5, 32'd1);
    idle(19);
    wr(4'h6, 32'd1);
    rdk(4'h7, 32'd0, "abort status");
    rdk(4'h8, 32'd0, "abort result");
    idle(70);
    wr(4'h5, 32'd1);
    idle(64);
    rd(4'h7, "rerun status");
    rd(4'h8, "rerun result_l");
    rd(4'h9, "rerun result_h");
    wr(4'h6, 32'd1);

    // operand write during EXEC ignored
    load(64'd7, 64'd7, 1'b1);
    wr(4'h5, 32'd1);
    idle(5);
    wr(4'h0, 32'd9);
    rdk(4'h0, 32'd7, "mcand_l held in exec");
    wr(4'h5, 32'd1);
    idle(56);
    rdk(4'h7, 32'd1, "7x7 done");
    rdk(4'h8, 32'd49, "7x7 result");
    wr(4'h6, 32'd1);

    // zero operand, reserved register
    load({$urandom, $urandom}, 64'd0, 1'b1);
    wr(4'h5, 32'd1);
    idle(63);
    rdk(4'h7, 32'd2, "zero still busy at 63");
    rdk(4'h7, 32'd1, "zero done");
    rdk(4'h8, 32'd0, "zero result_l");
    rdk(4'h9, 32'd0, "zero result_h");
    wr(4'hA, 32'hFFFFFFFF);
    rdk(4'hA, 32'd0, "reserved");
    wr(4'h6, 32'd1);

    // random operands with random bus traffic during EXEC
    for (int n = 0; n < 6; n++) begin
      a = (n == 0) ? 64'hFFFFFFFFFFFFFFFF : {$urandom, $urandom};
      b = (n == 0) ? 64'hFFFFFFFFFFFFFFFF : {$urandom, $urandom};
      if (n == 1) b = 64'd1;
      load(a, b, 1'($urandom_range(0, 1)));
      wr(4'h5, 32'd1);
      for (int c = 0; c < 64; c++) begin
        ra = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 3))
          0: idle(1);
          1: rd(ra, "random read");
          2: if (ra != 4'h6) wr(ra, $urandom); else idle(1);
          default: rd(4'h7, "random status");
        endcase
      end
      rd(4'h7, "random done status");
      rd(4'h8, "random result_l");
      rd(4'h9, "random result_h");
      wr(4'h6, 32'd1);
    end

    // reset in the middle of EXEC
    load(64'd11, 64'd13, 1'b1);
    wr(4'h5, 32'd1);
    idle(10);
    bus.s_sel = 1'b1; bus.s_wr = 1'b0; bus.s_addr = 4'h7; bus.s_din = '0;
    reset_n = 1'b0;
    model_reset();
    exp_dout_q.push_back(32'd0);
    exp_irq_q.push_back(1'b0);
    exp_tag_q.push_back("async reset");
    @(negedge clk);
    @(posedge clk);
    #3 reset_n = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) rdk(4'(i), 32'd0, "after reset");
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiplier_slave.md
MULTIPLIER_SLAVE -- requirements
Module: multiplier_slave

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below (clock and reset first).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port s_sel, input, 1 bit: slave selected by the bus this cycle.
REQ-005 The block SHALL have port s_wr, input, 1 bit: 1 = write, 0 = read; valid only when s_sel=1.
REQ-006 The block SHALL have port s_addr, input, 4 bits: register offset.
REQ-007 The block SHALL have port s_din, input, 32 bits: write data.
REQ-008 The block SHALL have port s_dout, output, 32 bits: read data.
REQ-009 The block SHALL have port m_interrupt, output, 1 bit: operation-complete interrupt to the bus master.
REQ-010 The block SHALL implement this register map (default after reset, meaning):
- 0x0 MCAND_L, 0, multiplicand[31:0], RW.
- 0x1 MCAND_H, 0, multiplicand[63:32], RW.
- 0x2 MPLIER_L, 0, multiplier[31:0], RW.
- 0x3 MPLIER_H, 0, multiplier[63:32], RW.
- 0x4 INTR_EN, 0, bit0 interrupt enable, RW.
- 0x5 OPSTART, -, write with s_din[0]=1 starts an operation; reads 0.
- 0x6 OPCLEAR, -, write with s_din[0]=1 clears; reads 0.
- 0x7 STATUS, 0, RO: bit0 done, bit1 busy, bit2 overflow.
- 0x8 RESULT_L, 0, product[31:0], RO.
- 0x9 RESULT_H, 0, product[63:32], RO.
- 0xA-0xF, -, reserved; reads 0, writes ignored.

Function
REQ-011 Writes SHALL take effect on the rising clk edge when s_sel=1 and s_wr=1.
REQ-012 s_dout SHALL be combinational: the addressed register when s_sel=1 and s_wr=0, otherwise 0.
REQ-013 The FSM SHALL have three states: IDLE (busy=0, done=0), EXEC (busy=1), DONE (done=1).
REQ-014 IDLE SHALL transition to EXEC on an OPSTART write with s_din[0]=1; in the same edge the 128-bit accumulator, RESULT and overflow SHALL clear, and the operands SHALL latch into working registers.
REQ-015 EXEC SHALL run radix-2 shift-add for exactly 64 cycles: if working-multiplier bit0=1, then accumulator += working multiplicand (128-bit); the multiplicand shifts left 1; the multiplier shifts right 1; a 6-bit counter increments.
REQ-016 On the 64th EXEC edge the FSM SHALL enter DONE and load RESULT = accumulator[63:0] and overflow = (accumulator[127:64] != 0); STATUS.done SHALL therefore be visible 65 cycles after the OPSTART edge.
REQ-017 m_interrupt SHALL equal STATUS.done AND INTR_EN[0], combinationally.
REQ-018 DONE SHALL hold until OPCLEAR; an OPSTART write in EXEC or DONE SHALL be ignored.
REQ-019 An OPCLEAR write with s_din[0]=1 in any state SHALL go to IDLE next edge and clear the accumulator, counter, RESULT, done and overflow; operands and INTR_EN SHALL be retained.
REQ-020 If OPSTART and OPCLEAR conditions cannot coincide (single address per cycle), no priority rule SHALL be needed; OPCLEAR in EXEC SHALL abort with no DONE.
REQ-021 Writes to MCAND_x or MPLIER_x during EXEC SHALL be ignored; in IDLE or DONE they SHALL be accepted.
REQ-022 A multiplier or multiplicand of 0 SHALL still take 64 cycles and yield RESULT 0, overflow 0.

Reset
REQ-023 When reset_n=0, asynchronously, the FSM SHALL go to IDLE and every register, counter and the accumulator SHALL go to 0; m_interrupt and s_dout SHALL be 0; reset during EXEC SHALL abort without a DONE.

Structure
REQ-024 Package multiplier_pkg SHALL hold the register offset constants, the STATUS bit positions and the 2-bit FSM state encodings (IDLE=00, EXEC=01, DONE=10).
REQ-025 The shift-add datapath (working registers, accumulator, counter) SHALL be a sub-module multiplier_core with start/clear/done handshake; register decode and the FSM SHALL remain in multiplier_slave.

Verification
REQ-026 The bench SHALL cover: MCAND=5, MPLIER=6, IE=1, OPSTART -> busy for 64 cycles, done and m_interrupt=1 at cycle 65, RESULT_L=30, RESULT_H=0, overflow=0.
REQ-027 The bench SHALL cover: MCAND=0x21C3677C82B40000 (20!), MPLIER=21 -> RESULT=0xC5077D36B8C40000 (low 64 bits), overflow=1.
REQ-028 The bench SHALL cover: IE=0, 3x4 -> STATUS.done=1, m_interrupt=0; then write IE=1 -> m_interrupt=1 with no new operation.
REQ-029 The bench SHALL cover: OPCLEAR at EXEC cycle 20 -> IDLE next edge, RESULT=0, no interrupt; then OPSTART again -> full correct result after 65 cycles.
REQ-030 The bench SHALL cover: writing MCAND_L=9 during EXEC of 7x7 -> RESULT=49, and MCAND_L reads back 7.
REQ-031 The bench SHALL cover: reset_n low mid-EXEC -> all outputs 0 immediately, and all registers read 0 after release.
